// File: rtl/player_anim_if.sv
// Signal bundle between game logic / video timing and the player animation controller.
// master = game/video side, slave = animation controller.
interface player_anim_if #(
  parameter int SPR_W        = 128,
  parameter int SPR_H        = 128,
  parameter int WALK_FRAMES  = 2,
  parameter int JUMP_FRAMES  = 3,
  parameter int PUNCH_FRAMES = 3
);
  localparam int NFRAMES = 3 + WALK_FRAMES + JUMP_FRAMES + PUNCH_FRAMES;
  localparam int XW      = $clog2(SPR_W);
  localparam int YW      = $clog2(SPR_H);
  localparam int FIDX_W  = $clog2(NFRAMES);
  localparam int ADDR_W  = $clog2(NFRAMES * SPR_W * SPR_H);

  logic              anim_tick;
  logic [6:0]        action;
  logic [XW-1:0]     px;
  logic [YW-1:0]     py;
  logic              px_valid;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_addr_vld;
  logic [FIDX_W-1:0] frame_idx;
  logic [2:0]        anim_state;
  logic              punch_active;

  modport master (
    output anim_tick, action, px, py, px_valid,
    input  rom_addr, rom_addr_vld, frame_idx, anim_state, punch_active
  );

  modport slave (
    input  anim_tick, action, px, py, px_valid,
    output rom_addr, rom_addr_vld, frame_idx, anim_state, punch_active
  );
endinterface

// File: rtl/player_anim_ctrl.sv
// Player animation controller: action decode, tick-paced frame sequencing and
// mirrored sprite-ROM addressing into one ROM holding all frames back to back.
module player_anim_ctrl #(
  parameter int SPR_W         = 128,
  parameter int SPR_H         = 128,
  parameter int WALK_FRAMES   = 2,
  parameter int JUMP_FRAMES   = 3,
  parameter int PUNCH_FRAMES  = 3,
  parameter int TICKS_PER_FRM = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  player_anim_if.slave bus
);
  localparam int STAND_BASE  = 0;
  localparam int WALK_BASE   = 1;
  localparam int CROUCH_BASE = 1 + WALK_FRAMES;
  localparam int SHIELD_BASE = CROUCH_BASE + 1;
  localparam int JUMP_BASE   = SHIELD_BASE + 1;
  localparam int PUNCH_BASE  = JUMP_BASE + JUMP_FRAMES;
  localparam int NFRAMES     = PUNCH_BASE + PUNCH_FRAMES;
  localparam int FRM_PIX     = SPR_W * SPR_H;
  localparam int ADDR_W      = $clog2(NFRAMES * FRM_PIX);
  localparam int XW          = $clog2(SPR_W);
  localparam int YW          = $clog2(SPR_H);
  localparam int FIDX_W      = $clog2(NFRAMES);
  localparam int TC_W        = (TICKS_PER_FRM > 1) ? $clog2(TICKS_PER_FRM) : 1;

  localparam logic [TC_W-1:0]   TC_LAST    = TC_W'(TICKS_PER_FRM - 1);
  localparam logic [FIDX_W-1:0] WALK_LAST  = FIDX_W'(WALK_FRAMES - 1);
  localparam logic [FIDX_W-1:0] JUMP_LAST  = FIDX_W'(JUMP_FRAMES - 1);
  localparam logic [FIDX_W-1:0] PUNCH_LAST = FIDX_W'(PUNCH_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_WALK   = 3'd1,
    ST_CROUCH = 3'd2,
    ST_SHIELD = 3'd3,
    ST_JUMP   = 3'd4,
    ST_PUNCH  = 3'd5
  } anim_state_t;

  function automatic anim_state_t decode_req(input logic [3:0] req_bits, input logic punch_edge);
    if (punch_edge)       decode_req = ST_PUNCH;
    else if (req_bits[3]) decode_req = ST_JUMP;
    else if (req_bits[2]) decode_req = ST_SHIELD;
    else if (req_bits[1]) decode_req = ST_CROUCH;
    else if (req_bits[0]) decode_req = ST_WALK;
    else                  decode_req = ST_STAND;
  endfunction

  function automatic logic [FIDX_W-1:0] state_base(input anim_state_t st);
    case (st)
      ST_WALK:   state_base = FIDX_W'(WALK_BASE);
      ST_CROUCH: state_base = FIDX_W'(CROUCH_BASE);
      ST_SHIELD: state_base = FIDX_W'(SHIELD_BASE);
      ST_JUMP:   state_base = FIDX_W'(JUMP_BASE);
      ST_PUNCH:  state_base = FIDX_W'(PUNCH_BASE);
      default:   state_base = FIDX_W'(STAND_BASE);
    endcase
  endfunction

  anim_state_t       state_r, state_n;
  anim_state_t       req_s, req_held_s;
  logic [FIDX_W-1:0] offset_r, offset_n;
  logic [TC_W-1:0]   tick_cnt_r, tick_cnt_n;
  logic              frame_done_s;
  logic              facing_r;
  logic              punch_prev_r;
  logic [FIDX_W-1:0] frame_idx_r;
  logic              punch_active_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              rom_addr_vld_r;
  logic [XW-1:0]     col_s;

  // Next animation state and in-sequence offset, evaluated for the coming tick.
  always_comb begin
    state_n      = state_r;
    offset_n     = offset_r;
    tick_cnt_n   = tick_cnt_r;
    req_s        = decode_req(bus.action[3:0], bus.action[4] & ~punch_prev_r);
    req_held_s   = decode_req(bus.action[3:0], 1'b0);
    frame_done_s = (tick_cnt_r == TC_LAST);
    if (state_r == ST_PUNCH) begin
      if (frame_done_s) begin
        tick_cnt_n = '0;
        if (offset_r == PUNCH_LAST) begin
          state_n  = req_held_s;
          offset_n = '0;
        end else begin
          offset_n = offset_r + FIDX_W'(1);
        end
      end else begin
        tick_cnt_n = tick_cnt_r + TC_W'(1);
      end
    end else if (req_s != state_r) begin
      state_n    = req_s;
      offset_n   = '0;
      tick_cnt_n = '0;
    end else if (frame_done_s) begin
      tick_cnt_n = '0;
      case (state_r)
        ST_WALK: offset_n = (offset_r == WALK_LAST) ? FIDX_W'(0) : offset_r + FIDX_W'(1);
        ST_JUMP: offset_n = (offset_r == JUMP_LAST) ? offset_r : offset_r + FIDX_W'(1);
        default: offset_n = '0;
      endcase
    end else begin
      tick_cnt_n = tick_cnt_r + TC_W'(1);
    end
  end

  // Animation registers move only on anim_tick so a frame never changes mid-scan.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r        <= ST_STAND;
      offset_r       <= '0;
      tick_cnt_r     <= '0;
      facing_r       <= 1'b0;
      punch_prev_r   <= 1'b0;
      frame_idx_r    <= '0;
      punch_active_r <= 1'b0;
    end else if (bus.anim_tick) begin
      state_r        <= state_n;
      offset_r       <= offset_n;
      tick_cnt_r     <= tick_cnt_n;
      punch_prev_r   <= bus.action[4];
      frame_idx_r    <= state_base(state_n) + offset_n;
      punch_active_r <= (state_n == ST_PUNCH);
      if (state_r != ST_PUNCH) begin
        facing_r <= bus.action[6];
      end
    end
  end

  // SPR_W is a power of two, so SPR_W-1-px is a bitwise inversion.
  assign col_s = facing_r ? ~bus.px : bus.px;

  // One-cycle address stage; the address is held while px_valid is low.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rom_addr_r     <= '0;
      rom_addr_vld_r <= 1'b0;
    end else begin
      rom_addr_vld_r <= bus.px_valid;
      if (bus.px_valid) begin
        rom_addr_r <= ADDR_W'({frame_idx_r, bus.py, col_s});
      end
    end
  end

  assign bus.rom_addr     = rom_addr_r;
  assign bus.rom_addr_vld = rom_addr_vld_r;
  assign bus.frame_idx    = frame_idx_r;
  assign bus.anim_state   = state_r;
  assign bus.punch_active = punch_active_r;

  // Only referenced through YW-sized py; keeps the sizing explicit.
  if (YW + XW + FIDX_W != ADDR_W) begin : g_addr_w_mismatch
    $error("sprite size must be a power of two");
  end
endmodule

// File: tb/tb_player_anim_ctrl.sv
// Randomized + directed bench for player_anim_ctrl with an elapsed-tick reference
// model and a queue scoreboard checked by a separate negedge monitor.
module tb_player_anim_ctrl;
  localparam int SPR_W = 128;
  localparam int SPR_H = 128;
  localparam int WF    = 2;
  localparam int JF    = 3;
  localparam int PF    = 3;
  localparam int TPF   = 4;
  localparam int XW    = $clog2(SPR_W);
  localparam int YW    = $clog2(SPR_H);

  // ROM order: stand, walk x WF, crouch, shield, jump x JF, punch x PF
  localparam int JUMP_B  = 3 + WF;
  localparam int PUNCH_B = 3 + WF + JF;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  player_anim_if #(.SPR_W(SPR_W), .SPR_H(SPR_H), .WALK_FRAMES(WF),
                   .JUMP_FRAMES(JF), .PUNCH_FRAMES(PF)) bus ();

  player_anim_ctrl #(.SPR_W(SPR_W), .SPR_H(SPR_H), .WALK_FRAMES(WF), .JUMP_FRAMES(JF),
                     .PUNCH_FRAMES(PF), .TICKS_PER_FRM(TPF)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  typedef struct {
    int frame;
    int state;
    int punch;
    int vld;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int base_of[6] = '{0, 1, 1 + WF, 2 + WF, 3 + WF, 3 + WF + JF};
  int m_state, m_elapsed, m_frame, m_addr, m_vld, m_facing, m_prev;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int decode(input logic [6:0] act, input int punch_edge);
    if (punch_edge != 0) return 5;
    if (act[3]) return 4;
    if (act[2]) return 3;
    if (act[1]) return 2;
    if (act[0]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_frame = 0; m_addr = 0;
    m_vld = 0; m_facing = 0; m_prev = 0;
  endtask

  // Frame is derived from ticks elapsed since entering the current animation.
  task automatic model_step(input int tick, input logic [6:0] act, input int px, input int py, input int vld);
    int req;
    int ofs;
    if (vld != 0) m_addr = m_frame * SPR_W * SPR_H + py * SPR_W + ((m_facing != 0) ? (SPR_W - 1 - px) : px);
    m_vld = vld;
    if (tick != 0) begin
      if (m_state == 5) begin
        m_elapsed++;
        if (m_elapsed == PF * TPF) begin
          m_state = decode(act, 0);
          m_elapsed = 0;
        end
      end else begin
        req = decode(act, (act[4] && m_prev == 0) ? 1 : 0);
        m_facing = act[6];
        if (req != m_state) begin
          m_state = req;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      m_prev = act[4];
      case (m_state)
        1: ofs = (m_elapsed / TPF) % WF;
        4: ofs = (m_elapsed / TPF < JF - 1) ? m_elapsed / TPF : JF - 1;
        5: ofs = m_elapsed / TPF;
        default: ofs = 0;
      endcase
      m_frame = base_of[m_state] + ofs;
    end
  endtask

  task automatic step_xy(input int tick, input logic [6:0] act, input int px, input int py, input int vld);
    exp_t e;
    bus.anim_tick = (tick != 0);
    bus.action    = act;
    bus.px        = XW'(px);
    bus.py        = YW'(py);
    bus.px_valid  = (vld != 0);
    @(posedge clk);
    model_step(tick, act, px, py, vld);
    e.frame = m_frame;
    e.state = m_state;
    e.punch = (m_state == 5) ? 1 : 0;
    e.vld   = m_vld;
    e.addr  = m_addr;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic step(input int tick, input logic [6:0] act, input int vld);
    step_xy(tick, act, $urandom_range(0, SPR_W - 1), $urandom_range(0, SPR_H - 1), vld);
  endtask

  // Scoreboard monitor: one expected record per clock, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_frame_idx", int'(bus.frame_idx), e.frame);
        chk("sb_anim_state", int'(bus.anim_state), e.state);
        chk("sb_punch_active", int'(bus.punch_active), e.punch);
        chk("sb_rom_addr_vld", int'(bus.rom_addr_vld), e.vld);
        chk("sb_rom_addr", int'(bus.rom_addr), e.addr);
      end
    end
  end

  initial begin : stim
    int walk_exp[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    logic [6:0] cur_act;
    int kind;
    bus.anim_tick = 1'b0; bus.action = 7'd0; bus.px = '0; bus.py = '0; bus.px_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    chk("reset_frame_idx", int'(bus.frame_idx), 0);
    chk("reset_anim_state", int'(bus.anim_state), 0);
    chk("reset_rom_addr_vld", int'(bus.rom_addr_vld), 0);

    // Walk loop from STAND
    step(1, 7'b0100000, 0);
    chk("stand_frame", int'(bus.frame_idx), 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 7'b0000001, 1);
      chk("walk_seq", int'(bus.frame_idx), walk_exp[i]);
    end

    // Asynchronous reset in the middle of a walk
    step(1, 7'b0000001, 1);
    step(0, 7'b0000001, 1);
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("async_rst_frame_idx", int'(bus.frame_idx), 0);
    chk("async_rst_anim_state", int'(bus.anim_state), 0);
    chk("async_rst_rom_addr", int'(bus.rom_addr), 0);
    chk("async_rst_rom_addr_vld", int'(bus.rom_addr_vld), 0);
    chk("async_rst_punch_active", int'(bus.punch_active), 0);
    model_reset();
    @(posedge clk);
    #1 rst_l = 1'b1;
    step(1, 7'b0100000, 0);
    chk("post_rst_stand", int'(bus.anim_state), 0);

    // Mirroring: left-facing, then right-facing, then hold with px_valid low
    step(1, 7'b1100000, 0);
    step_xy(0, 7'b1100000, 0, 2, 1);
    chk("mirror_left_addr", int'(bus.rom_addr), 383);
    chk("mirror_left_vld", int'(bus.rom_addr_vld), 1);
    step(1, 7'b0100000, 0);
    step_xy(0, 7'b0100000, 0, 2, 1);
    chk("mirror_right_addr", int'(bus.rom_addr), 256);
    step_xy(0, 7'b0100000, 9, 9, 0);
    chk("addr_hold", int'(bus.rom_addr), 256);
    chk("addr_hold_vld", int'(bus.rom_addr_vld), 0);

    // Punch lock: walk/direction noise ignored, exits to STAND with punch held
    for (int i = 0; i < PF * TPF; i++) begin
      if (i == 0) step(1, 7'b0010000, 1);
      else step(1, {1'($urandom_range(0, 1)), 5'b00100, 1'($urandom_range(0, 1))}, 1);
      chk("punch_frame", int'(bus.frame_idx), PUNCH_B + i / TPF);
      chk("punch_active", int'(bus.punch_active), 1);
    end
    step(1, 7'b0010000, 1);
    chk("punch_exit_state", int'(bus.anim_state), 0);
    chk("punch_exit_active", int'(bus.punch_active), 0);
    repeat (5) step(1, 7'b0010000, 1);
    chk("punch_held_no_retrigger", int'(bus.anim_state), 0);

    // Jump hold saturates on the last frame, release exits next tick
    for (int i = 0; i < 20; i++) begin
      step(1, 7'b0001000, 0);
      chk("jump_frame", int'(bus.frame_idx), JUMP_B + ((i / TPF < JF - 1) ? i / TPF : JF - 1));
    end
    step(1, 7'b0000000, 0);
    chk("jump_release", int'(bus.frame_idx), 0);

    // Priority and no-tick hold
    step(1, 7'b0000011, 0);
    chk("prio_crouch_frame", int'(bus.frame_idx), 1 + WF);
    for (int i = 0; i < 10; i++) begin
      step(0, 7'($urandom_range(0, 127)), 1);
      chk("no_tick_hold", int'(bus.frame_idx), 1 + WF);
    end

    // Randomized phase: held actions, sparse ticks, random pixel scan
    cur_act = 7'b0100000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        kind = $urandom_range(0, 8);
        if (kind == 0) cur_act = 7'd0;
        else if (kind <= 6) cur_act = 7'(1 << (kind - 1));
        else cur_act = 7'($urandom_range(0, 63));
        cur_act[6] = 1'($urandom_range(0, 1));
      end
      step(($urandom_range(0, 2) == 0) ? 1 : 0, cur_act, $urandom_range(0, 1));
    end

    bus.px_valid = 1'b0;
    bus.anim_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
